// File: rtl/bp_pkg.sv
// Shared types for the tournament branch predictor update scheduler.
// An in-flight entry holds everything needed to train the predictor at resolve time.
package bp_pkg;

  localparam int BP_IDX_W = 10;
  localparam int BP_DEPTH = 4;

  typedef struct packed {
    logic [BP_IDX_W-1:0] meta_idx;
    logic                pred_outcome;
    logic                pred_global;
    logic                pred_local;
    logic [BP_IDX_W-1:0] global_idx;
    logic [BP_IDX_W-1:0] local_idx;
  } bp_entry_t;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } bp_state_e;

endpackage

// File: rtl/bp_inflight_fifo.sv
// Circular buffer of in-flight predictions in program order.
// truncate pops the head and discards everything younger; clear empties the buffer.
module bp_inflight_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = BP_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  bp_entry_t        push_data,
  input  logic             pop,
  input  logic             truncate,
  input  logic             clear,
  output bp_entry_t        head_data,
  output logic [CNT_W-1:0] count
);

  bp_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  assign head_data = mem[head];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (truncate) begin
      // The resolved head leaves and the younger wrong-path entries vanish with it.
      head  <= head + PTR_W'(1);
      tail  <= head + PTR_W'(1);
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_data;
  end

endmodule

// File: rtl/bp_update_scheduler.sv
// Issues fetch-time predictor reads, tracks in-flight predictions, and drives the
// single predictor write port when EX resolves the oldest branch.
module bp_update_scheduler
  import bp_pkg::*;
#(
  parameter int DEPTH = BP_DEPTH,
  parameter int IDX_W = BP_IDX_W,
  localparam int OCC_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_br_valid,
  input  logic [IDX_W-1:0] fetch_idx,
  output logic             fetch_stall,
  output logic             pred_read,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             pred_outcome,
  input  logic             pred_global,
  input  logic             pred_local,
  input  logic [IDX_W-1:0] pred_global_idx,
  input  logic [IDX_W-1:0] pred_local_idx,
  input  logic             resolve_valid,
  input  logic             resolve_taken,
  output logic             resolve_mispredict,
  input  logic             flush,
  output logic             upd_write,
  output logic             upd_outcome,
  output logic [IDX_W-1:0] upd_idx,
  output logic             upd_global_pred,
  output logic             upd_local_pred,
  output logic [IDX_W-1:0] upd_global_idx,
  output logic [IDX_W-1:0] upd_local_idx,
  output logic [OCC_W-1:0] occupancy,
  output logic             err_sticky,
  output bp_state_e        state
);

  // Handshake: an allocation happens on the edge where pred_read is high and a pop
  // on the edge where resolve_valid meets a non-empty queue without flush; there is
  // no back-pressure on resolve, so a resolve with nothing in flight is an error.
  bp_state_e state_q;
  bp_state_e state_d;
  bp_entry_t head_entry;
  bp_entry_t new_entry;
  logic      full;
  logic      empty;
  logic      resolve_ok;

  assign state = state_q;
  assign empty = (occupancy == '0);
  assign full  = (occupancy == OCC_W'(DEPTH));

  assign fetch_stall        = full | (state_q == RECOVER);
  assign resolve_ok         = resolve_valid & ~empty & ~flush & ~rst;
  assign resolve_mispredict = resolve_ok & (head_entry.pred_outcome != resolve_taken);
  assign pred_read          = ~rst & fetch_br_valid & ~fetch_stall & ~flush & ~resolve_mispredict;
  assign pred_idx           = fetch_idx;

  always_comb begin
    new_entry              = '0;
    new_entry.meta_idx     = fetch_idx;
    new_entry.pred_outcome = pred_outcome;
    new_entry.pred_global  = pred_global;
    new_entry.pred_local   = pred_local;
    new_entry.global_idx   = pred_global_idx;
    new_entry.local_idx    = pred_local_idx;
  end

  bp_inflight_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (pred_read),
    .push_data (new_entry),
    .pop       (resolve_ok),
    .truncate  (resolve_mispredict),
    .clear     (flush),
    .head_data (head_entry),
    .count     (occupancy)
  );

  always_comb begin
    state_d = state_q;
    if (flush)                     state_d = RUN;
    else if (state_q == RECOVER)   state_d = RUN;
    else if (resolve_mispredict)   state_d = RECOVER;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // A write registered before a flush still completes; flush only blocks new ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      upd_write       <= 1'b0;
      upd_outcome     <= 1'b0;
      upd_idx         <= '0;
      upd_global_pred <= 1'b0;
      upd_local_pred  <= 1'b0;
      upd_global_idx  <= '0;
      upd_local_idx   <= '0;
      err_sticky      <= 1'b0;
    end else begin
      upd_write <= resolve_ok;
      if (resolve_ok) begin
        upd_outcome     <= resolve_taken;
        upd_idx         <= head_entry.meta_idx;
        upd_global_pred <= head_entry.pred_global;
        upd_local_pred  <= head_entry.pred_local;
        upd_global_idx  <= head_entry.global_idx;
        upd_local_idx   <= head_entry.local_idx;
      end
      if (resolve_valid && empty) err_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Directed bench for bp_update_scheduler: queue-based model checked every cycle,
// plus hand-computed expectations along the directed sequence.
module tb_bp_update_scheduler;
  import bp_pkg::*;

  localparam int DEPTH = 4;
  localparam int IDX_W = 10;
  localparam int OCC_W = 3;
  localparam int ENT_W = 3 * IDX_W + 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             fetch_br_valid = 1'b0;
  logic [IDX_W-1:0] fetch_idx = '0;
  logic             fetch_stall;
  logic             pred_read;
  logic [IDX_W-1:0] pred_idx;
  logic             pred_outcome = 1'b0;
  logic             pred_global = 1'b0;
  logic             pred_local = 1'b0;
  logic [IDX_W-1:0] pred_global_idx = '0;
  logic [IDX_W-1:0] pred_local_idx = '0;
  logic             resolve_valid = 1'b0;
  logic             resolve_taken = 1'b0;
  logic             resolve_mispredict;
  logic             flush = 1'b0;
  logic             upd_write;
  logic             upd_outcome;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_global_pred;
  logic             upd_local_pred;
  logic [IDX_W-1:0] upd_global_idx;
  logic [IDX_W-1:0] upd_local_idx;
  logic [OCC_W-1:0] occupancy;
  logic             err_sticky;
  bp_state_e        state;

  bp_update_scheduler #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk                (clk),
    .rst                (rst),
    .fetch_br_valid     (fetch_br_valid),
    .fetch_idx          (fetch_idx),
    .fetch_stall        (fetch_stall),
    .pred_read          (pred_read),
    .pred_idx           (pred_idx),
    .pred_outcome       (pred_outcome),
    .pred_global        (pred_global),
    .pred_local         (pred_local),
    .pred_global_idx    (pred_global_idx),
    .pred_local_idx     (pred_local_idx),
    .resolve_valid      (resolve_valid),
    .resolve_taken      (resolve_taken),
    .resolve_mispredict (resolve_mispredict),
    .flush              (flush),
    .upd_write          (upd_write),
    .upd_outcome        (upd_outcome),
    .upd_idx            (upd_idx),
    .upd_global_pred    (upd_global_pred),
    .upd_local_pred     (upd_local_pred),
    .upd_global_idx     (upd_global_idx),
    .upd_local_idx      (upd_local_idx),
    .occupancy          (occupancy),
    .err_sticky         (err_sticky),
    .state              (state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: entries {idx, outcome, global, local, global_idx, local_idx} in program order
  logic [ENT_W-1:0] exp_q[$];
  logic [ENT_W-1:0] m_upd = '0;
  logic             m_upd_v = 1'b0;
  logic             m_upd_o = 1'b0;
  logic             m_rec = 1'b0;
  logic             m_err = 1'b0;
  logic             model_ok = 1'b0;

  always @(posedge clk) begin
    int sz;
    logic [ENT_W-1:0] h;
    logic e_stall, e_mis, e_read;
    if (rst) begin
      exp_q.delete();
      m_upd = '0; m_upd_v = 1'b0; m_upd_o = 1'b0;
      m_rec = 1'b0; m_err = 1'b0; model_ok = 1'b1;
    end else if (model_ok) begin
      sz = exp_q.size();
      h = (sz > 0) ? exp_q[0] : '0;
      e_stall = (sz == DEPTH) || m_rec;
      e_mis   = resolve_valid && !flush && sz > 0 && (h[22] != resolve_taken);
      e_read  = fetch_br_valid && !e_stall && !flush && !e_mis;
      m_upd_v = 1'b0;
      if (resolve_valid && sz == 0) m_err = 1'b1;
      if (flush) begin
        exp_q.delete();
        m_rec = 1'b0;
      end else begin
        if (resolve_valid && sz > 0) begin
          m_upd   = exp_q.pop_front();
          m_upd_o = resolve_taken;
          m_upd_v = 1'b1;
        end
        if (e_mis) exp_q.delete();
        m_rec = e_mis;
        if (e_read)
          exp_q.push_back({fetch_idx, pred_outcome, pred_global, pred_local,
                           pred_global_idx, pred_local_idx});
      end
    end
  end

  // Scoreboard compare, every cycle once the model is seeded by reset
  always @(negedge clk) begin
    int sz;
    logic [ENT_W-1:0] h;
    logic e_stall, e_mis, e_read;
    if (model_ok) begin
      sz = exp_q.size();
      h = (sz > 0) ? exp_q[0] : '0;
      e_stall = (sz == DEPTH) || m_rec;
      e_mis   = !rst && resolve_valid && !flush && sz > 0 && (h[22] != resolve_taken);
      e_read  = !rst && fetch_br_valid && !e_stall && !flush && !e_mis;
      chk("sb_fetch_stall", 32'(fetch_stall), 32'(e_stall));
      chk("sb_pred_read", 32'(pred_read), 32'(e_read));
      chk("sb_pred_idx", 32'(pred_idx), 32'(fetch_idx));
      chk("sb_mispredict", 32'(resolve_mispredict), 32'(e_mis));
      chk("sb_occupancy", 32'(occupancy), 32'(sz));
      chk("sb_err_sticky", 32'(err_sticky), 32'(m_err));
      chk("sb_state", 32'(state), 32'(m_rec));
      chk("sb_upd_write", 32'(upd_write), 32'(m_upd_v));
      if (m_upd_v) begin
        chk("sb_upd_entry", {upd_idx, upd_global_pred, upd_local_pred, upd_global_idx,
                             upd_local_idx}, {m_upd[32:23], m_upd[21:10], m_upd[9:0]});
        chk("sb_upd_outcome", 32'(upd_outcome), 32'(m_upd_o));
      end
    end
  end

  // Driver tasks: inputs change 1 time unit after the rising edge
  task automatic drive(input logic fv, input logic [IDX_W-1:0] idx, input logic po,
                       input logic rv, input logic rt, input logic fl);
    @(posedge clk);
    #1;
    fetch_br_valid  = fv;
    fetch_idx       = idx;
    pred_outcome    = po;
    pred_global     = po;
    pred_local      = ~po;
    pred_global_idx = idx ^ 10'h155;
    pred_local_idx  = idx + 10'd1;
    resolve_valid   = rv;
    resolve_taken   = rt;
    flush           = fl;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic alloc(input logic [IDX_W-1:0] idx, input logic po);
    drive(1'b1, idx, po, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic resolve(input logic rt);
    drive(1'b0, '0, 1'b0, 1'b1, rt, 1'b0);
  endtask

  initial begin
    idle();
    idle();
    rst = 1'b0;
    idle();
    chk("rst_occupancy", 32'(occupancy), 0);
    chk("rst_upd_write", 32'(upd_write), 0);
    chk("rst_fetch_stall", 32'(fetch_stall), 0);
    chk("rst_err", 32'(err_sticky), 0);

    // Three allocations
    alloc(10'h010, 1'b1);
    chk("t1_pred_read", 32'(pred_read), 1);
    chk("t1_pred_idx", 32'(pred_idx), 32'h010);
    alloc(10'h020, 1'b0);
    alloc(10'h030, 1'b1);
    chk("t1_stall", 32'(fetch_stall), 0);
    idle();
    chk("t1_occupancy", 32'(occupancy), 3);

    // Fill, stall on the fifth, then a correct resolve
    alloc(10'h040, 1'b0);
    alloc(10'h050, 1'b1);
    chk("t2_stall", 32'(fetch_stall), 1);
    chk("t2_pred_read", 32'(pred_read), 0);
    chk("t2_occupancy", 32'(occupancy), 4);
    resolve(1'b1);
    chk("t2_no_mispredict", 32'(resolve_mispredict), 0);
    idle();
    chk("t2_upd_write", 32'(upd_write), 1);
    chk("t2_upd_idx", 32'(upd_idx), 32'h010);
    chk("t2_occupancy_after", 32'(occupancy), 3);

    // Mispredict with three queued and a same-cycle fetch
    resolve(1'b0);
    alloc(10'h060, 1'b0);
    drive(1'b1, 10'h070, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t3_mispredict", 32'(resolve_mispredict), 1);
    chk("t3_read_suppressed", 32'(pred_read), 0);
    idle();
    chk("t3_upd_write", 32'(upd_write), 1);
    chk("t3_upd_outcome", 32'(upd_outcome), 0);
    chk("t3_upd_idx", 32'(upd_idx), 32'h030);
    chk("t3_occupancy", 32'(occupancy), 0);
    chk("t3_state", 32'(state), 32'(RECOVER));
    chk("t3_stall", 32'(fetch_stall), 1);
    idle();
    chk("t3_stall_released", 32'(fetch_stall), 0);
    chk("t3_state_run", 32'(state), 32'(RUN));

    // Correct resolve plus alloc in the same cycle
    alloc(10'h070, 1'b0);
    alloc(10'h080, 1'b1);
    drive(1'b1, 10'h090, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t4_pred_read", 32'(pred_read), 1);
    idle();
    chk("t4_occupancy", 32'(occupancy), 2);
    chk("t4_upd_write", 32'(upd_write), 1);
    chk("t4_upd_gidx", 32'(upd_global_idx), 32'h125);
    chk("t4_upd_lidx", 32'(upd_local_idx), 32'h071);

    // Flush with a resolve, then an empty resolve, then a write that crosses a flush
    alloc(10'h0a0, 1'b0);
    drive(1'b1, 10'h0a8, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t5_no_mispredict", 32'(resolve_mispredict), 0);
    chk("t5_no_read", 32'(pred_read), 0);
    idle();
    chk("t5_occupancy", 32'(occupancy), 0);
    chk("t5_no_upd", 32'(upd_write), 0);
    chk("t5_err_clear", 32'(err_sticky), 0);
    resolve(1'b1);
    idle();
    chk("t5_err_set", 32'(err_sticky), 1);
    alloc(10'h0b0, 1'b1);
    resolve(1'b1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t5_upd_across_flush", 32'(upd_write), 1);
    chk("t5_upd_idx", 32'(upd_idx), 32'h0b0);
    idle();
    chk("t5_err_holds", 32'(err_sticky), 1);

    // Nine push/pop pairs wrap the pointers
    alloc(10'h100, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 10'h100 + IDX_W'(i), 1'(i & 1), 1'b1, 1'((i - 1) & 1), 1'b0);
      if (i >= 2) chk("t6_upd_idx", 32'(upd_idx), 32'h100 + 32'(i - 2));
    end
    resolve(1'b0);
    chk("t6_upd_idx_7", 32'(upd_idx), 32'h107);
    idle();
    chk("t6_upd_idx_8", 32'(upd_idx), 32'h108);
    chk("t6_occupancy", 32'(occupancy), 0);

    // Only reset clears the error flag
    rst = 1'b1;
    idle();
    rst = 1'b0;
    idle();
    chk("end_err_cleared", 32'(err_sticky), 0);
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/bp_update_scheduler.md
Name: bp_update_scheduler

Overview:
- Sequences the tournament branch predictor.
- Issues the fetch-time predictor read and keeps each in-flight prediction (choice, local/global outcomes, local/global indices) in program order.
- When EX resolves a branch, drives the single predictor write port and flags mispredicts. Sits between IF, EX and the predictor instance.

Parameters:
- DEPTH, 4, max in-flight predicted branches; power of two, at least 2.
- IDX_W, 10, predictor index width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- fetch_br_valid  in  1  IF holds a branch needing a prediction this cycle.
- fetch_idx  in  IDX_W  PC-derived predictor index.
- fetch_stall  out  1  IF must hold; allocation refused.
- pred_read  out  1  predictor read strobe.
- pred_idx  out  IDX_W  predictor read index.
- pred_outcome  in  1  final predicted direction (same cycle as pred_read).
- pred_global  in  1  global component prediction.
- pred_local  in  1  local component prediction.
- pred_global_idx  in  IDX_W  global table index used.
- pred_local_idx  in  IDX_W  local table index used.
- resolve_valid  in  1  EX resolves the oldest branch.
- resolve_taken  in  1  actual direction.
- resolve_mispredict  out  1  oldest entry's prediction differs from resolve_taken.
- flush  in  1  non-branch squash (trap/jump); discard all entries.
- upd_write  out  1  predictor write strobe.
- upd_outcome  out  1  actual direction.
- upd_idx  out  IDX_W  meta-table index (the original fetch_idx).
- upd_global_pred  out  1  saved global prediction.
- upd_local_pred  out  1  saved local prediction.
- upd_global_idx  out  IDX_W  saved global index.
- upd_local_idx  out  IDX_W  saved local index.
- occupancy  out  log2(DEPTH)+1  live entry count.
- err_sticky  out  1  protocol error seen.

Behaviour:
- Reset:
  - clk is the only clock. rst is synchronous, active-high.
  - Reset empties the queue and sets head = tail = 0, FSM = RUN.
  - All outputs reset to 0 except pred_idx, which follows fetch_idx.
  - Reset mid-operation drops every entry with no write issued.
- FSM has two states, RUN and RECOVER.
  - RUN -> RECOVER on an accepted resolve with mispredict.
  - RECOVER -> RUN unconditionally after 1 cycle.
  - flush in either state -> RUN.
  - rst has priority over flush; flush has priority over resolve, which has priority over alloc.
- fetch_stall = (occupancy == DEPTH) OR (state == RECOVER). It is combinational.
- pred_read = fetch_br_valid AND NOT fetch_stall AND NOT flush AND NOT resolve_mispredict.
  - pred_idx = fetch_idx.
- Allocation: when pred_read is high, write {fetch_idx, pred_outcome, pred_global, pred_local, pred_global_idx, pred_local_idx} at tail on the clock edge, then increment tail (wraps mod DEPTH).
- Resolve (accepted only when occupancy > 0):
  - resolve_mispredict = resolve_valid AND occupancy > 0 AND (head.pred_outcome != resolve_taken), combinational.
  - On the edge, pop head.
  - The next cycle: upd_write = 1 for exactly one cycle; upd_* come from the popped entry; upd_outcome = resolve_taken.
  - Write latency is 1 cycle from resolve.
- Mispredict:
  - After the pop, discard all younger entries (tail = head+1, occupancy = 0).
  - A same-cycle allocation is suppressed (pred_read already low).
  - Enter RECOVER.
- Simultaneous resolve (correct prediction) and alloc: both take effect; occupancy unchanged.
  - When full, fetch_stall still blocks the alloc that cycle; no bypass.
- flush:
  - Clears all entries and returns to RUN.
  - A same-cycle resolve is dropped: no upd_write, no mispredict.
  - An upd_write already registered from the previous cycle still completes.
- Errors:
  - resolve_valid with occupancy 0 is ignored and sets err_sticky.
  - err_sticky clears only on rst.
- Width rule: occupancy is one bit wider than the pointers so full and empty are distinguishable.

Decomposition:
- Package bp_pkg holds:
  - IDX_W default constant.
  - bp_entry_t packed struct (meta_idx, pred_outcome, pred_global, pred_local, global_idx, local_idx).
  - bp_state_e enum {RUN, RECOVER}.
- One sub-module, bp_inflight_fifo: a DEPTH x bp_entry_t circular buffer with push, pop, and truncate-to-head (mispredict) / clear (flush) controls. The FSM and write register stay in bp_update_scheduler.

Test Plan:
1. Reset, then 3 allocs (idx 0x010, 0x020, 0x030) -> occupancy 3, pred_read high each cycle, fetch_stall 0.
2. Fill 4 entries; 5th fetch_br_valid -> fetch_stall 1, pred_read 0, occupancy stays 4. Resolve matching head -> next cycle upd_write 1, upd_idx 0x010, occupancy 3.
3. Head pred_outcome 1, resolve_taken 0 with 3 entries queued -> resolve_mispredict 1 same cycle; next cycle upd_write 1, upd_outcome 0, occupancy 0, state RECOVER, fetch_stall 1 for one cycle, then 0.
4. Correct resolve and alloc in the same cycle at occupancy 2 -> occupancy stays 2; upd_write next cycle with the old head's saved global/local idx.
5. flush with resolve_valid at occupancy 3 -> occupancy 0, no upd_write, resolve_mispredict 0. resolve_valid at occupancy 0 -> err_sticky 1, stays 1 until rst.
6. Push/pop 9 times at DEPTH 4 -> pointer wrap is correct; upd_idx order matches alloc order.
